// File: rtl/mat3_dot_mac.sv
// mat3_dot_mac: 3x3 dot-product MAC; sums three a*b terms per element, buffers nine results, drains them in order.
// Build option: define MAT3_SATURATE_EN to clamp stored results to the signed OW range instead of wrapping.
module mat3_dot_mac #(
    parameter int DW = 8,
    parameter int AW = 2*DW+2,
    parameter int OW = 2*DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_in,
    input  logic signed [DW-1:0] b_in,
    input  logic [1:0]           k_in,
    input  logic [3:0]           sel_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic [3:0]           out_idx,
    output logic                 busy,
    output logic                 err_seq
);
    typedef enum logic [1:0] {ACC, FLUSH, DRAIN} state_t;
    state_t state, state_nx;
    logic [1:0] exp_k, k1;
    logic [3:0] exp_sel, sel1, rd_ptr;
    logic signed [2*DW-1:0] p1;
    logic v1, err, in_fire, legal, bad, out_fire;
    logic signed [AW-1:0] acc, sum;
    logic signed [OW-1:0] wdata;
    logic signed [OW-1:0] mem [0:8];

    assign in_ready  = (state == ACC) && en && reset;
    assign in_fire   = in_valid && in_ready;
    assign legal     = in_fire && k_in == exp_k && sel_in == exp_sel && sel_in >= 4'd1 && sel_in <= 4'd9;
    assign bad       = in_fire && !legal;
    assign out_valid = (state == DRAIN) && reset;
    assign out_fire  = out_valid && out_ready && en;
    assign out_idx   = out_valid ? rd_ptr : 4'd0;
    assign out_data  = out_valid ? mem[rd_ptr - 4'd1] : '0;
    assign busy      = reset && (state != ACC || exp_k != 2'd0 || exp_sel != 4'd1 || v1);
    assign err_seq   = err && reset;
    assign sum       = (k1 == 2'd0 ? '0 : acc) + {{(AW-2*DW){p1[2*DW-1]}}, p1};

`ifdef MAT3_SATURATE_EN
    // The sum fits OW when all bits from the OW sign bit upward agree.
    assign wdata = (&sum[AW-1:OW-1] || ~|sum[AW-1:OW-1]) ? sum[OW-1:0] :
                   sum[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
`else
    assign wdata = sum[OW-1:0];
`endif

    always_comb begin
        state_nx = state;
        state_nx = (state == ACC && legal && k_in == 2'd2 && sel_in == 4'd9) ? FLUSH :
                   (state == FLUSH && en) ? DRAIN :
                   (out_fire && rd_ptr == 4'd9) ? ACC : state;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= ACC;
        else state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            exp_k   <= 2'd0;
            exp_sel <= 4'd1;
            v1      <= 1'b0;
            acc     <= '0;
            err     <= 1'b0;
            rd_ptr  <= 4'd1;
        end else if (en) begin
            v1 <= legal;
            if (legal) begin
                p1      <= (2*DW)'(a_in) * (2*DW)'(b_in);
                k1      <= k_in;
                sel1    <= sel_in;
                exp_k   <= exp_k == 2'd2 ? 2'd0 : exp_k + 2'd1;
                exp_sel <= exp_k != 2'd2 ? exp_sel : exp_sel == 4'd9 ? 4'd1 : exp_sel + 4'd1;
            end else if (bad) begin
                exp_k <= 2'd0;
                err   <= 1'b1;
            end
            // An illegal transfer abandons the element; a pending k=2 still completes its own write.
            if (bad) acc <= '0;
            else if (v1) acc <= sum;
            if (state == FLUSH) rd_ptr <= 4'd1;
            else if (out_fire) rd_ptr <= rd_ptr + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && en && v1 && k1 == 2'd2) mem[sel1 - 4'd1] <= wdata;
    end
endmodule

// File: tb/tb_mat3_dot_mac.sv
// tb_mat3_dot_mac: scoreboard bench for mat3_dot_mac (honours MAT3_SATURATE_EN in its model).
module tb_mat3_dot_mac;
    logic clk = 0, reset = 0, en = 1, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, busy, err_seq;
    logic signed [7:0] a_in = 0, b_in = 0;
    logic [1:0] k_in = 0;
    logic [3:0] sel_in = 0, out_idx;
    logic signed [15:0] out_data;
    int checks = 0, errors = 0;

    typedef struct {int idx; logic [15:0] data;} exp_t;
    exp_t q[$];

    mat3_dot_mac dut (.clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .k_in(k_in), .sel_in(sel_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .busy(busy), .err_seq(err_seq));

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input int s);
`ifdef MAT3_SATURATE_EN
        return s > 32767 ? 16'h7FFF : s < -32768 ? 16'h8000 : 16'(s);
`else
        return 16'(s);
`endif
    endfunction

    task automatic send_pair(input int a, input int b, input int k, input int s);
        int t = 0;
        a_in = 8'(a); b_in = 8'(b); k_in = 2'(k); sel_in = 4'(s); in_valid = 1; #1;
        while (!in_ready && t < 200) begin @(negedge clk); #1; t++; end
        checks++;
        if (!in_ready) begin errors++; $display("FAIL send_timeout in_ready=%b required 1", in_ready); end
        @(negedge clk);
        in_valid = 0;
    endtask

    // mode 0: a=1,b=2; 1: -128*-128; 2: random; 3: a=3,b=3
    task automatic run_matrix(input int first_sel, input int mode, input int npairs, input int gap_at);
        int s = 0;
        for (int i = 0; i < npairs; i++) begin
            int a, b, sel, k;
            sel = first_sel + i / 3; k = i % 3;
            a = mode == 0 ? 1 : mode == 1 ? -128 : mode == 3 ? 3 : $signed(8'($urandom));
            b = mode == 0 ? 2 : mode == 1 ? -128 : mode == 3 ? 3 : $signed(8'($urandom));
            if (i == gap_at) begin
                a_in = 8'(a); b_in = 8'(b); k_in = 2'(k); sel_in = 4'(sel); in_valid = 1; en = 0;
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0) begin errors++; $display("FAIL en_gap_in_ready got=%b required 0", in_ready); end
                end
                en = 1;
            end
            send_pair(a, b, k, sel);
            s = (k == 0 ? 0 : s) + a * b;
            if (k == 2) q.push_back('{sel, model(s)});
        end
    endtask

    task automatic drain(input int stall_idx, input int gap_idx);
        int n = 0, cyc = 0;
        bit stalled = 0, gapped = 0;
        exp_t e;
        while (n < 9 && cyc < 1000) begin
            @(negedge clk); cyc++;
            out_ready = 1; en = 1;
            if (out_valid && out_idx == 4'(stall_idx) && !stalled && q.size() > 0) begin
                stalled = 1; out_ready = 0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    checks++;
                    if (out_idx !== 4'(stall_idx) || out_data !== q[0].data || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_hold idx=%0d data=%h in_ready=%b valid=%b required idx=%0d data=%h in_ready=0 valid=1",
                                 out_idx, out_data, in_ready, out_valid, stall_idx, q[0].data);
                    end
                end
                out_ready = 1;
            end
            if (out_valid && out_idx == 4'(gap_idx) && !gapped && q.size() > 0) begin
                gapped = 1; en = 0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    checks++;
                    if (out_idx !== 4'(gap_idx) || out_data !== q[0].data || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL en_gap_drain idx=%0d data=%h valid=%b required idx=%0d data=%h valid=1",
                                 out_idx, out_data, out_valid, gap_idx, q[0].data);
                    end
                end
                en = 1;
            end
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL unexpected_output idx=%0d data=%h", out_idx, out_data);
                end else begin
                    e = q.pop_front();
                    if (out_idx !== 4'(e.idx) || out_data !== e.data) begin
                        errors++;
                        $display("FAIL result idx=%0d data=%h required idx=%0d data=%h", out_idx, out_data, e.idx, e.data);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n < 9) begin errors++; $display("FAIL drain_timeout results=%0d required 9", n); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_drain valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
        end
        q.delete();
    endtask

    task automatic test_reset;
        reset = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_data, out_idx, busy, err_seq} !== '0) begin
            errors++;
            $display("FAIL reset_outputs in_ready=%b valid=%b data=%h idx=%0d busy=%b err=%b required all 0",
                     in_ready, out_valid, out_data, out_idx, busy, err_seq);
        end
        reset = 1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic;
        run_matrix(1, 0, 27, -1);
        drain(0, 0);
    endtask

    task automatic test_extreme_with_stall;
        run_matrix(1, 1, 27, -1);
        drain(4, 0);
    endtask

    task automatic test_seq_err;
        send_pair(1, 1, 0, 1);
        send_pair(1, 1, 2, 1);
        checks++;
        if (err_seq !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL seq_err err=%b busy=%b required 1 0", err_seq, busy);
        end
        run_matrix(1, 3, 27, -1);
        drain(0, 0);
        checks++;
        if (err_seq !== 1'b1) begin errors++; $display("FAIL err_sticky err=%b required 1", err_seq); end
    endtask

    task automatic test_mid_reset;
        run_matrix(1, 2, 14, -1);
        send_pair(1, 1, 0, 7);
        reset = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || err_seq !== 1'b0) begin
            errors++; $display("FAIL mid_reset busy=%b valid=%b err=%b required 0 0 0", busy, out_valid, err_seq);
        end
        reset = 1;
        q.delete();
        @(negedge clk);
        run_matrix(1, 2, 27, -1);
        drain(0, 0);
    endtask

    task automatic test_en_toggle;
        run_matrix(1, 2, 27, 13);
        drain(0, 6);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_extreme_with_stall;
        test_seq_err;
        test_mid_reset;
        test_en_toggle;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
